// File: rtl/pipe_hazard_fwd_pkg.sv
// Shared constants and helpers for the hazard-detection / forwarding controller.
package pipe_hazard_fwd_pkg;
   localparam int unsigned DATA_W_DEF = 16;
   localparam int unsigned NREG_DEF   = 16;
   localparam int unsigned NSRC_DEF   = 3;
   localparam int unsigned NDST_DEF   = 2;
   localparam int unsigned NSLOT_DEF  = 3;
   localparam int unsigned CNT_W_DEF  = 16;

   // Result-producing slot encodings for id_res_stage.
   localparam int unsigned RES_ALU  = 0;
   localparam int unsigned RES_LOAD = 1;

   // Index width that stays at least one bit for degenerate sizes.
   function automatic int unsigned idx_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/pipe_hazard_fwd_match.sv
// Priority search for one source operand over all in-flight slots.
// Youngest slot (lowest index) wins, then lowest destination index within the slot.
module pipe_hazard_fwd_match
   import pipe_hazard_fwd_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned AW     = 4,
   parameter int unsigned NDST   = NDST_DEF,
   parameter int unsigned NSLOT  = NSLOT_DEF
) (
   input  logic [AW-1:0]                           src_addr,
   input  logic                                    src_used,
   input  logic [NSLOT-1:0]                        slot_valid,
   input  logic [NSLOT-1:0][NDST-1:0][AW-1:0]      slot_dst_addr,
   input  logic [NSLOT-1:0][NDST-1:0]              slot_dst_en,
   input  logic [NSLOT-1:0]                        slot_avail,
   input  logic [NSLOT-1:0][NDST-1:0][DATA_W-1:0]  slot_data,
   output logic                                    hit,
   output logic                                    avail,
   output logic [DATA_W-1:0]                       data
);

   // Scan oldest-to-youngest so the last assignment is the highest-priority match.
   always_comb begin
      hit   = 1'b0;
      avail = 1'b0;
      data  = '0;
      for (int k = NSLOT - 1; k >= 0; k--) begin
         for (int j = NDST - 1; j >= 0; j--) begin
            if (src_used && slot_valid[k] && slot_dst_en[k][j] &&
                (slot_dst_addr[k][j] == src_addr)) begin
               hit   = 1'b1;
               avail = slot_avail[k];
               data  = slot_data[k][j];
            end
         end
      end
   end

endmodule

// File: rtl/pipe_hazard_fwd.sv
// Hazard detection and operand forwarding with a shift-register scoreboard from EX to WB.
// Also drives register-file writeback from the last slot and counts stall cycles.
module pipe_hazard_fwd
   import pipe_hazard_fwd_pkg::*;
#(
   parameter  int unsigned DATA_W = DATA_W_DEF,
   parameter  int unsigned NREG   = NREG_DEF,
   parameter  int unsigned NSRC   = NSRC_DEF,
   parameter  int unsigned NDST   = NDST_DEF,
   parameter  int unsigned NSLOT  = NSLOT_DEF,
   parameter  int unsigned CNT_W  = CNT_W_DEF,
   localparam int unsigned AW     = idx_w(NREG),
   localparam int unsigned SW     = idx_w(NSLOT)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          id_valid,
   input  logic                          flush,
   input  logic [NSRC*AW-1:0]            id_src_addr,
   input  logic [NSRC-1:0]               id_src_used,
   input  logic [NDST*AW-1:0]            id_dst_addr,
   input  logic [NDST-1:0]               id_dst_en,
   input  logic [SW-1:0]                 id_res_stage,
   input  logic [NSLOT*NDST*DATA_W-1:0]  res_data,
   output logic                          stall,
   output logic [NSRC-1:0]               fwd_sel,
   output logic [NSRC*DATA_W-1:0]        fwd_data,
   output logic [NDST-1:0]               wb_en,
   output logic [NDST*AW-1:0]            wb_addr,
   output logic [NDST*DATA_W-1:0]        wb_data,
   output logic [CNT_W-1:0]              stall_cnt
);

   logic [NSLOT-1:0]                        valid_q, valid_d, rdy_q, rdy_d;
   logic [NSLOT-1:0][NDST-1:0][AW-1:0]      dst_addr_q, dst_addr_d;
   logic [NSLOT-1:0][NDST-1:0]              dst_en_q, dst_en_d;
   logic [NSLOT-1:0][SW-1:0]                res_stage_q, res_stage_d;
   logic [NSLOT-1:0][NDST-1:0][DATA_W-1:0]  data_q, data_d;
   logic [CNT_W-1:0]                        stall_cnt_q, stall_cnt_d;

   logic [NSLOT-1:0][NDST-1:0][DATA_W-1:0]  res_data_a;
   logic [NSLOT-1:0]                        stage_here, slot_avail;
   logic [NSLOT-1:0][NDST-1:0][DATA_W-1:0]  avail_data;
   logic [NSRC-1:0]                         m_hit, m_avail, hazard;
   logic [NSRC-1:0][DATA_W-1:0]             m_data;
   logic [SW-1:0]                           id_stage_clamped;
   logic                                    issue;

   assign res_data_a = res_data;

   assign id_stage_clamped = ({1'b0, id_res_stage} < (SW+1)'(NSLOT)) ? id_res_stage
                                                                    : SW'(NSLOT - 1);

   // Invalid slots contribute nothing, so bubbles never pick up stray res_data.
   always_comb begin
      stage_here = '0;
      slot_avail = '0;
      avail_data = '0;
      for (int k = 0; k < NSLOT; k++) begin
         stage_here[k] = (res_stage_q[k] == SW'(k));
         slot_avail[k] = valid_q[k] & (rdy_q[k] | stage_here[k]);
         for (int j = 0; j < NDST; j++) begin
            if (valid_q[k])
               avail_data[k][j] = stage_here[k] ? res_data_a[k][j] : data_q[k][j];
         end
      end
   end

   for (genvar i = 0; i < NSRC; i++) begin : g_match
      pipe_hazard_fwd_match #(
         .DATA_W (DATA_W),
         .AW     (AW),
         .NDST   (NDST),
         .NSLOT  (NSLOT)
      ) u_match (
         .src_addr      (id_src_addr[i*AW +: AW]),
         .src_used      (id_src_used[i]),
         .slot_valid    (valid_q),
         .slot_dst_addr (dst_addr_q),
         .slot_dst_en   (dst_en_q),
         .slot_avail    (slot_avail),
         .slot_data     (avail_data),
         .hit           (m_hit[i]),
         .avail         (m_avail[i]),
         .data          (m_data[i])
      );
   end

   always_comb begin
      fwd_sel  = '0;
      fwd_data = '0;
      hazard   = '0;
      for (int i = 0; i < NSRC; i++) begin
         fwd_sel[i] = m_hit[i] & m_avail[i];
         hazard[i]  = m_hit[i] & ~m_avail[i];
         if (fwd_sel[i])
            fwd_data[i*DATA_W +: DATA_W] = m_data[i];
      end
   end

   // flush overrides a hazard: no stall, and the killed instruction becomes a bubble.
   assign stall = id_valid & ~flush & (|hazard);
   assign issue = id_valid & ~flush & ~stall;

   always_comb begin
      valid_d     = '0;
      rdy_d       = '0;
      dst_addr_d  = '0;
      dst_en_d    = '0;
      res_stage_d = '0;
      data_d      = '0;
      if (issue) begin
         valid_d[0]     = 1'b1;
         dst_addr_d[0]  = id_dst_addr;
         dst_en_d[0]    = id_dst_en;
         res_stage_d[0] = id_stage_clamped;
      end
      for (int k = 1; k < NSLOT; k++) begin
         valid_d[k]     = valid_q[k-1];
         dst_addr_d[k]  = dst_addr_q[k-1];
         dst_en_d[k]    = dst_en_q[k-1];
         res_stage_d[k] = res_stage_q[k-1];
         rdy_d[k]       = slot_avail[k-1];
         data_d[k]      = avail_data[k-1];
      end
   end

   assign stall_cnt_d = (stall && !(&stall_cnt_q)) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_q     <= '0;
         rdy_q       <= '0;
         dst_addr_q  <= '0;
         dst_en_q    <= '0;
         res_stage_q <= '0;
         data_q      <= '0;
         stall_cnt_q <= '0;
      end else begin
         valid_q     <= valid_d;
         rdy_q       <= rdy_d;
         dst_addr_q  <= dst_addr_d;
         dst_en_q    <= dst_en_d;
         res_stage_q <= res_stage_d;
         data_q      <= data_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign wb_en     = {NDST{valid_q[NSLOT-1]}} & dst_en_q[NSLOT-1];
   assign wb_addr   = dst_addr_q[NSLOT-1];
   assign wb_data   = avail_data[NSLOT-1];
   assign stall_cnt = stall_cnt_q;

   a_res_stage_legal: assert property (@(posedge clk) disable iff (!rst)
      id_valid |-> ({1'b0, id_res_stage} < (SW+1)'(NSLOT)));

endmodule
